// File: rtl/leaf_out_arbiter_if.sv
// Requester-side and output-side handshake bundle for leaf_out_arbiter.
// master = arbiter view (drives ack_req and the output word); slave = kernels plus leaf_interface.
interface leaf_out_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int IDX_BITS     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req;
  logic [NUM_REQ-1:0]              vld_req;
  logic [NUM_REQ-1:0]              ack_req;
  logic [PAYLOAD_BITS-1:0]         dout;
  logic [IDX_BITS-1:0]             dout_idx;
  logic                            vld_out;
  logic                            ack_in;

  modport master (
    input  din_req, vld_req, ack_in,
    output ack_req, dout, dout_idx, vld_out
  );

  modport slave (
    output din_req, vld_req, ack_in,
    input  ack_req, dout, dout_idx, vld_out
  );
endinterface

// File: rtl/leaf_out_arbiter.sv
// Round-robin burst arbiter onto one vld/ack port; accepted word appears on dout 1 cycle later.
// A requester is acked only while the output register is empty or draining; ARB_STATS_EN adds counters.
module leaf_out_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int MAX_BURST    = 8,
  parameter int IDX_BITS     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  leaf_out_arbiter_if.master bus,
  output logic [31:0]        stat_xfer_cnt,
  output logic [31:0]        stat_stall_cnt
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]       LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(NUM_REQ - 1);

  typedef enum logic {ST_IDLE, ST_LOCK} state_e;

  state_e                  state_q, state_d;
  logic [IDX_BITS-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_BITS-1:0]     grant_q, grant_d;
  logic [IDX_BITS-1:0]     dout_idx_q, dout_idx_d;
  logic [BW-1:0]           burst_cnt_q, burst_cnt_d;
  logic [PAYLOAD_BITS-1:0] dout_q, dout_d;
  logic                    vld_out_q, vld_out_d;

  logic [PAYLOAD_BITS-1:0] sel_dat;
  logic                    sel_vld;
  logic [NUM_REQ-1:0]      ack_req;
  logic [IDX_BITS-1:0]     pick, cand;
  logic                    pick_found;
  logic                    space;
  logic                    xfer;

  function automatic logic [IDX_BITS-1:0] next_idx(input logic [IDX_BITS-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  // Output slot can take a word when empty or when its current word leaves this cycle.
  assign space = !vld_out_q || bus.ack_in;
  assign xfer  = (state_q == ST_LOCK) && sel_vld && space;

  always_comb begin
    sel_dat = '0;
    sel_vld = 1'b0;
    ack_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_BITS'(i)) begin
        sel_dat = bus.din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        sel_vld = bus.vld_req[i];
      end
      ack_req[i] = (state_q == ST_LOCK) && (grant_q == IDX_BITS'(i)) && bus.vld_req[i] && space;
    end
  end

  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && bus.vld_req[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
      cand = next_idx(cand);
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    dout_d      = dout_q;
    dout_idx_d  = dout_idx_q;
    vld_out_d   = vld_out_q;

    if (xfer) begin
      dout_d      = sel_dat;
      dout_idx_d  = grant_q;
      vld_out_d   = 1'b1;
      burst_cnt_d = burst_cnt_q + 1'b1;
    end else if (bus.ack_in) begin
      vld_out_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d     = pick;
          burst_cnt_d = '0;
          state_d     = ST_LOCK;
        end
      end
      ST_LOCK: begin
        // Release on a full burst or as soon as the owner stops presenting data.
        if ((xfer && burst_cnt_q == LAST_BEAT) || !sel_vld) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_idx(grant_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      dout_q      <= '0;
      dout_idx_q  <= '0;
      vld_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      dout_q      <= dout_d;
      dout_idx_q  <= dout_idx_d;
      vld_out_q   <= vld_out_d;
    end
  end

  assign bus.ack_req  = ack_req;
  assign bus.dout     = dout_q;
  assign bus.dout_idx = dout_idx_q;
  assign bus.vld_out  = vld_out_q;

`ifdef ARB_STATS_EN
  logic [31:0] xfer_cnt_q, xfer_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (vld_out_q && bus.ack_in && xfer_cnt_q != 32'hFFFF_FFFF)
      xfer_cnt_d = xfer_cnt_q + 32'd1;
    if (vld_out_q && !bus.ack_in && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_xfer_cnt  = xfer_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  assign stat_xfer_cnt  = '0;
  assign stat_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Bench for leaf_out_arbiter: directed scenarios plus random traffic, all checked cycle by cycle
// against a transaction-level model (owner index, words sent, one-deep output slot).
module tb_leaf_out_arbiter;
  localparam int N  = 4;
  localparam int PB = 32;
  localparam int MB = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] stat_xfer, stat_stall;

  leaf_out_arbiter_if #(.NUM_REQ(N), .PAYLOAD_BITS(PB), .IDX_BITS(2)) bus ();

  leaf_out_arbiter #(
    .NUM_REQ(N), .PAYLOAD_BITS(PB), .MAX_BURST(MB), .IDX_BITS(2)
  ) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .stat_xfer_cnt  (stat_xfer),
    .stat_stall_cnt (stat_stall)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner = -1 when nobody holds the port.
  int          m_owner, m_sent, m_ptr, m_idx;
  bit          m_vld;
  logic [31:0] m_dat;
  longint      m_xfer, m_stall;

  function automatic void model_reset();
    m_owner = -1; m_sent = 0; m_ptr = 0; m_idx = 0;
    m_vld = 1'b0; m_dat = '0; m_xfer = 0; m_stall = 0;
  endfunction

  function automatic logic [N-1:0] model_ack(input logic [N-1:0] vld, input logic ack_in);
    logic [N-1:0] a;
    a = '0;
    if (m_owner >= 0 && vld[m_owner] && (!m_vld || ack_in)) a[m_owner] = 1'b1;
    return a;
  endfunction

  function automatic void model_step(input logic [N-1:0] vld, input logic [N*PB-1:0] din,
                                     input logic ack_in);
    logic [N-1:0] a;
    bit found;
    int o;
    a = model_ack(vld, ack_in);
    if (m_vld && ack_in)  m_xfer++;
    if (m_vld && !ack_in) m_stall++;
    if (m_owner < 0) begin
      if (ack_in) m_vld = 1'b0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && vld[(m_ptr + k) % N]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % N;
          m_sent  = 0;
        end
      end
    end else begin
      o = m_owner;
      if (a[o]) begin
        m_vld = 1'b1;
        m_dat = din[o*PB +: PB];
        m_idx = o;
        m_sent++;
      end else if (ack_in) begin
        m_vld = 1'b0;
      end
      if ((a[o] && m_sent == MB) || !vld[o]) begin
        m_ptr   = (o + 1) % N;
        m_owner = -1;
      end
    end
  endfunction

  function automatic logic [N*PB-1:0] rand_din();
    logic [N*PB-1:0] d;
    for (int i = 0; i < N; i++) d[i*PB +: PB] = $urandom;
    return d;
  endfunction

  function automatic logic [N*PB-1:0] lane(input int i, input logic [31:0] w);
    logic [N*PB-1:0] d;
    d = rand_din();
    d[i*PB +: PB] = w;
    return d;
  endfunction

  task automatic check_stats();
`ifdef ARB_STATS_EN
    check_eq("stat_xfer", stat_xfer, m_xfer);
    check_eq("stat_stall", stat_stall, m_stall);
`else
    check_eq("stat_xfer_off", stat_xfer, 0);
    check_eq("stat_stall_off", stat_stall, 0);
`endif
  endtask

  // One clock: drive at negedge, check ack before the edge, check outputs just after it.
  task automatic step(input logic [N-1:0] vld, input logic [N*PB-1:0] din, input logic ack_in,
                      output logic [N-1:0] ack_seen);
    @(negedge clk);
    bus.vld_req = vld;
    bus.din_req = din;
    bus.ack_in  = ack_in;
    #1;
    ack_seen = bus.ack_req;
    check_eq("ack_req", bus.ack_req, model_ack(vld, ack_in));
    @(posedge clk);
    model_step(vld, din, ack_in);
    #1;
    check_eq("vld_out", bus.vld_out, m_vld);
    check_eq("dout", bus.dout, m_dat);
    check_eq("dout_idx", bus.dout_idx, m_idx);
    check_stats();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    bus.vld_req = '0;
    bus.ack_in  = 1'b0;
    #1;
    model_reset();
    check_eq("rst_vld_out", bus.vld_out, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  logic [N-1:0]  a;
  logic [N-1:0]  cur_vld;
  logic [31:0]   words [3];
  logic [N-1:0]  exp_ack;

  initial begin
    bus.vld_req = 4'hF;
    bus.ack_in  = 1'b1;
    bus.din_req = '0;
    model_reset();

    // Reset held with all requesters valid.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack_req", bus.ack_req, 0);
    check_eq("rst_vld_out", bus.vld_out, 0);
    check_eq("rst_dout", bus.dout, 0);
    check_stats();
    #1 reset_n = 1'b1;
    step(4'hF, rand_din(), 1'b1, a);
    check_eq("rst_first_idle", a, 0);
    step(4'hF, rand_din(), 1'b1, a);
    check_eq("rst_grant0", a, 4'b0001);

    // Single stream, words visible one cycle after accept.
    do_reset();
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
    step(4'b0010, rand_din(), 1'b1, a);
    for (int w = 0; w < 3; w++) begin
      step(4'b0010, lane(1, words[w]), 1'b1, a);
      check_eq("single_ack", a, 4'b0010);
      check_eq("single_dout", bus.dout, words[w]);
      check_eq("single_idx", bus.dout_idx, 1);
    end

    // Burst limit: 8 words idx0, idle, 8 words idx2, idle, 8 words idx0.
    do_reset();
    for (int c = 0; c < 27; c++) begin
      step(4'b0101, rand_din(), 1'b1, a);
      if (c == 0 || c == 9 || c == 18) exp_ack = 4'b0000;
      else if (c > 9 && c < 18)        exp_ack = 4'b0100;
      else                             exp_ack = 4'b0001;
      check_eq("burst_seq", a, exp_ack);
    end

    // Backpressure: 0x55 held for 5 stalled cycles.
    do_reset();
    step(4'b0001, lane(0, 32'h55), 1'b1, a);
    step(4'b0001, lane(0, 32'h55), 1'b1, a);
    check_eq("bp_first", bus.dout, 32'h55);
    for (int c = 0; c < 5; c++) begin
      step(4'b0001, lane(0, 32'h66), 1'b0, a);
      check_eq("bp_ack_low", a, 0);
      check_eq("bp_hold", bus.dout, 32'h55);
      check_eq("bp_vld_hold", bus.vld_out, 1);
    end
`ifdef ARB_STATS_EN
    check_eq("bp_stall5", stat_stall, 5);
`endif
    step(4'b0001, lane(0, 32'h66), 1'b1, a);
    check_eq("bp_resume_ack", a, 4'b0001);
    check_eq("bp_resume_dout", bus.dout, 32'h66);

    // Drop: req3 sends 2 words then deasserts; pointer wraps to 0.
    do_reset();
    step(4'b1000, rand_din(), 1'b1, a);
    step(4'b1000, rand_din(), 1'b1, a);
    check_eq("drop_w0", a, 4'b1000);
    step(4'b1000, rand_din(), 1'b1, a);
    check_eq("drop_w1", a, 4'b1000);
    step(4'b0001, rand_din(), 1'b1, a);
    check_eq("drop_release", a, 0);
    step(4'b1001, rand_din(), 1'b1, a);
    check_eq("drop_idle", a, 0);
    step(4'b1001, rand_din(), 1'b1, a);
    check_eq("drop_next0", a, 4'b0001);

    // Async reset mid-burst with pointer moved away from 0.
    do_reset();
    repeat (3) step(4'b0001, rand_din(), 1'b1, a);
    step(4'b0000, rand_din(), 1'b1, a);
    step(4'b0100, rand_din(), 1'b1, a);
    step(4'b0100, rand_din(), 1'b0, a);
    step(4'b0100, rand_din(), 1'b0, a);
    check_eq("mid_vld_before", bus.vld_out, 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_vld_async", bus.vld_out, 0);
    check_eq("mid_dout_async", bus.dout, 0);
    check_eq("mid_xfer_async", stat_xfer, 0);
    check_eq("mid_stall_async", stat_stall, 0);
    model_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
    step(4'hF, rand_din(), 1'b1, a);
    step(4'hF, rand_din(), 1'b1, a);
    check_eq("mid_regrant0", a, 4'b0001);

    // Random traffic with sticky valids so bursts often run to the limit.
    do_reset();
    cur_vld = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) cur_vld[i] = ~cur_vld[i];
      step(cur_vld, rand_din(), ($urandom_range(0, 4) != 0), a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
